multdiv_issue: RTL and testbench

Issue/hold stage that sits directly upstream of the iterative multiplier and divider.
- Accepts one mult/div op from the execute stage and latches the operands.
- Fires the one-cycle ctrl_MULT/ctrl_DIV start pulse and holds unit operands stable for the whole iteration; the divider reads sign bits combinationally until done.
- Waits for RDY, captures the result or exception, and presents it to writeback with a destination tag.
- Stalls the pipeline while busy.

---
 rtl/multdiv_pkg.sv | 44 ++++
 rtl/multdiv_timer.sv | 37 +++
 rtl/multdiv_issue.sv | 206 ++++++++++++++++++++
 tb/tb_multdiv_issue.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the mult/div issue/hold stage.
// Optional build macro used by multdiv_issue: MULTDIV_FASTZERO_EN.
package multdiv_pkg;

  // Issue stage FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Operation encoding on in_op
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Default parameter values
  localparam int          DEF_TIMEOUT       = 64;
  localparam logic [4:0]  DEF_EXC_REG       = 5'd30;
  localparam logic [31:0] DEF_MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DEF_DIV_EXC_CODE  = 32'd5;

  // Writeback payload
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } wb_t;

  // Build the exception completion for the given op
  function automatic wb_t exc_completion(
    input logic        op,
    input logic [4:0]  exc_reg,
    input logic [31:0] mult_code,
    input logic [31:0] div_code
  );
    wb_t r;
    r.rd   = exc_reg;
    r.data = (op == OP_DIV) ? div_code : mult_code;
    r.exc  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/multdiv_timer.sv
// Launch-to-ready watchdog counter for the mult/div issue stage.
// tc flags the WAIT cycle whose closing edge brings the count to TIMEOUT-1.
// TIMEOUT must be at least 2.
module multdiv_timer
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int             CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  TC_VAL = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0]  ONE    = CW'(1);

  logic [CW-1:0] count_r;

  // Cycle counter: cleared on launch, counts while waiting, holds otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = en && (count_r == TC_VAL);

endmodule

// File: rtl/multdiv_issue.sv
// Issue/hold stage in front of the iterative multiplier and divider.
// Latches one op, fires a one-cycle start pulse, holds operands stable,
// waits for the unit (or a timeout) and presents the result to writeback.
// Optional build macro: MULTDIV_FASTZERO_EN (div by zero completes in IDLE).
module multdiv_issue
  import multdiv_pkg::*;
#(
  parameter int          TIMEOUT       = DEF_TIMEOUT,
  parameter logic [4:0]  EXC_REG       = DEF_EXC_REG,
  parameter logic [31:0] MULT_EXC_CODE = DEF_MULT_EXC_CODE,
  parameter logic [31:0] DIV_EXC_CODE  = DEF_DIV_EXC_CODE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] unit_result,
  input  logic        unit_exception,
  input  logic        unit_rdy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  input  logic        wb_ack
);

  state_e      state_r;
  state_e      state_n;
  logic        accept_s;
  logic        fastzero_s;
  logic        tmr_clr_s;
  logic        tmr_en_s;
  logic        tmr_tc_s;

  logic        op_r;
  logic [4:0]  rd_r;
  logic [31:0] a_r;
  logic [31:0] b_r;

  wb_t         wb_r;
  wb_t         wb_n;
  logic        wb_valid_r;
  logic        wb_valid_n;
  logic        stall_r;
  logic        stall_n;
  logic        mult_r;
  logic        mult_n;
  logic        div_r;
  logic        div_n;

  assign tmr_clr_s = (state_r == ST_LAUNCH);
  assign tmr_en_s  = (state_r == ST_WAIT);

  multdiv_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr_s),
    .en    (tmr_en_s),
    .tc    (tmr_tc_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; flush aborts everything except a finished result
  always_comb begin
    state_n    = state_r;
    accept_s   = 1'b0;
    fastzero_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          accept_s = 1'b1;
`ifdef MULTDIV_FASTZERO_EN
          if ((in_op == OP_DIV) && (in_b == 32'd0)) begin
            fastzero_s = 1'b1;
            state_n    = ST_DONE;
          end else begin
            state_n    = ST_LAUNCH;
          end
`else
          state_n = ST_LAUNCH;
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (flush) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_n = ST_IDLE;
        end else if (unit_rdy || tmr_tc_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (wb_ack) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Operand/op/destination latch; only an accepted op may change them
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= OP_MULT;
      rd_r <= 5'd0;
      a_r  <= 32'd0;
      b_r  <= 32'd0;
    end else if (accept_s) begin
      op_r <= in_op;
      rd_r <= in_rd;
      a_r  <= in_a;
      b_r  <= in_b;
    end else begin
      op_r <= op_r;
      rd_r <= rd_r;
      a_r  <= a_r;
      b_r  <= b_r;
    end
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    stall_n    = (state_n != ST_IDLE);
    mult_n     = (state_n == ST_LAUNCH) && (in_op == OP_MULT);
    div_n      = (state_n == ST_LAUNCH) && (in_op == OP_DIV);
    wb_valid_n = (state_n == ST_DONE);
    wb_n       = '0;
    if (state_n == ST_DONE) begin
      if (state_r == ST_DONE) begin
        wb_n = wb_r;
      end else if (fastzero_s) begin
        wb_n = exc_completion(OP_DIV, EXC_REG, MULT_EXC_CODE, DIV_EXC_CODE);
      end else if (unit_rdy && !unit_exception) begin
        wb_n.rd   = rd_r;
        wb_n.data = unit_result;
        wb_n.exc  = 1'b0;
      end else begin
        // unit-reported exception or watchdog expiry
        wb_n = exc_completion(op_r, EXC_REG, MULT_EXC_CODE, DIV_EXC_CODE);
      end
    end else begin
      wb_n = '0;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_r    <= 1'b0;
      mult_r     <= 1'b0;
      div_r      <= 1'b0;
      wb_valid_r <= 1'b0;
      wb_r       <= '0;
    end else begin
      stall_r    <= stall_n;
      mult_r     <= mult_n;
      div_r      <= div_n;
      wb_valid_r <= wb_valid_n;
      wb_r       <= wb_n;
    end
  end

  assign stall        = stall_r;
  assign ctrl_MULT    = mult_r;
  assign ctrl_DIV     = div_r;
  assign unit_a       = a_r;
  assign unit_b       = b_r;
  assign wb_valid     = wb_valid_r;
  assign wb_rd        = wb_r.rd;
  assign wb_data      = wb_r.data;
  assign wb_exception = wb_r.exc;

endmodule

// File: tb/tb_multdiv_issue.sv
// Scoreboard bench for multdiv_issue: stimulus pushes expected writebacks,
// a negedge monitor pops and compares them on each wb handshake.
module tb_multdiv_issue;
  import multdiv_pkg::*;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        flush;
  logic        stall;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] unit_result;
  logic        unit_exception;
  logic        unit_rdy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        wb_ack;

  int   total = 0;
  int   bad = 0;
  int   mult_pulses = 0;
  int   div_pulses = 0;
  int   cycles = 0;
  int   p0;
  wb_t  exp_q[$];
  wb_t  held_wb;
  wb_t  got_e;
  logic held = 1'b0;

  always #5 clk = ~clk;

  multdiv_issue dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_op          (in_op),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_rd          (in_rd),
    .flush          (flush),
    .stall          (stall),
    .unit_a         (unit_a),
    .unit_b         (unit_b),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .unit_result    (unit_result),
    .unit_exception (unit_exception),
    .unit_rdy       (unit_rdy),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_exception   (wb_exception),
    .wb_ack         (wb_ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data, input logic exc);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    e.exc  = exc;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic ack_one();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
  endtask

  // Monitor: pulse accounting, hold stability and scoreboard pop on handshake
  always @(negedge clk) begin
    if (ctrl_MULT && ctrl_DIV) begin
      chk("pulse_exclusive", 32'd1, 32'd0);
    end
    if (ctrl_MULT) mult_pulses++;
    if (ctrl_DIV)  div_pulses++;
    if (reset) begin
      held = 1'b0;
    end else if (wb_valid) begin
      if (held) begin
        chk("wb_hold_rd", {27'd0, wb_rd}, {27'd0, held_wb.rd});
        chk("wb_hold_data", wb_data, held_wb.data);
        chk("wb_hold_exc", {31'd0, wb_exception}, {31'd0, held_wb.exc});
      end
      if (wb_ack) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: got rd=%0d data=%0h with empty scoreboard", wb_rd, wb_data);
        end else begin
          got_e = exp_q.pop_front();
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, got_e.rd});
          chk("wb_data", wb_data, got_e.data);
          chk("wb_exc", {31'd0, wb_exception}, {31'd0, got_e.exc});
        end
      end else begin
        held         = 1'b1;
        held_wb.rd   = wb_rd;
        held_wb.data = wb_data;
        held_wb.exc  = wb_exception;
      end
    end else begin
      held = 1'b0;
    end
  end

  // Watchdog so the run always ends
  always @(posedge clk) begin
    cycles++;
    if (cycles > 20000) begin
      $display("FAIL watchdog: cycles=%0d limit=20000", cycles);
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_a = 32'd0; in_b = 32'd0;
    in_rd = 5'd0; flush = 1'b0; unit_result = 32'd0; unit_exception = 1'b0;
    unit_rdy = 1'b0; wb_ack = 1'b0;
    tick();
    tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
    chk("rst_unit_a", unit_a, 32'd0);
    chk("rst_unit_b", unit_b, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_exc", {31'd0, wb_exception}, 32'd0);
    reset = 1'b0;
    tick();

    // flush beats in_valid in IDLE
    flush = 1'b1;
    issue(OP_MULT, 32'd77, 32'd88, 5'd1);
    flush = 1'b0;
    chk("flushwin_stall", {31'd0, stall}, 32'd0);
    chk("flushwin_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
    chk("flushwin_unit_a", unit_a, 32'd0);

    // div 100/7, rdy after 34 cycles
    p0 = div_pulses;
    push_exp(5'd5, 32'd14, 1'b0);
    issue(OP_DIV, 32'd100, 32'd7, 5'd5);
    chk("div_pulse_t1", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd1);
    chk("div_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("div_pulse_gone", {31'd0, ctrl_DIV}, 32'd0);
    for (int i = 0; i < 33; i++) tick();
    chk("div_unit_a_stable", unit_a, 32'd100);
    chk("div_unit_b_stable", unit_b, 32'd7);
    chk("div_no_early_wb", {31'd0, wb_valid}, 32'd0);
    unit_rdy = 1'b1; unit_result = 32'd14;
    tick();
    unit_rdy = 1'b0; unit_result = 32'd0;
    chk("div_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("div_pulse_count", div_pulses - p0, 32'd1);
    ack_one();
    chk("div_idle_after_ack", {31'd0, stall}, 32'd0);

    // div by zero
    p0 = div_pulses;
    push_exp(5'd30, 32'd5, 1'b1);
    issue(OP_DIV, 32'd9, 32'd0, 5'd6);
`ifdef MULTDIV_FASTZERO_EN
    chk("dz_fast_no_pulse", {31'd0, ctrl_DIV}, 32'd0);
    chk("dz_fast_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("dz_fast_pulse_count", div_pulses - p0, 32'd0);
`else
    chk("dz_pulse", {31'd0, ctrl_DIV}, 32'd1);
    tick();
    tick();
    unit_rdy = 1'b1; unit_exception = 1'b1; unit_result = 32'hDEADBEEF;
    tick();
    unit_rdy = 1'b0; unit_exception = 1'b0; unit_result = 32'd0;
    chk("dz_wb_valid", {31'd0, wb_valid}, 32'd1);
`endif
    ack_one();

    // mult timeout, rdy never asserted
    p0 = mult_pulses;
    push_exp(5'd30, 32'd4, 1'b1);
    issue(OP_MULT, 32'd3, 32'd5, 5'd7);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("to_not_yet", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("to_pulse_count", mult_pulses - p0, 32'd1);
    ack_one();

    // flush in WAIT, stale rdy ignored, then mult 6*7
    issue(OP_DIV, 32'd50, 32'd5, 5'd9);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    unit_rdy = 1'b1; unit_result = 32'd10;
    tick();
    unit_rdy = 1'b0;
    chk("stale_rdy_stall", {31'd0, stall}, 32'd0);
    chk("stale_rdy_wb", {31'd0, wb_valid}, 32'd0);
    push_exp(5'd3, 32'd42, 1'b0);
    issue(OP_MULT, 32'd6, 32'd7, 5'd3);
    chk("m67_pulse", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd2);
    unit_rdy = 1'b1; unit_result = 32'd99;
    tick();
    unit_rdy = 1'b0;
    chk("launch_rdy_ignored", {31'd0, wb_valid}, 32'd0);
    unit_rdy = 1'b1; unit_result = 32'd42;
    tick();
    unit_rdy = 1'b0; unit_result = 32'd0;
    chk("m67_wb_valid", {31'd0, wb_valid}, 32'd1);

    // ack held low 5 cycles with a new op waiting; flush in DONE ignored
    in_valid = 1'b1; in_op = OP_MULT; in_a = 32'd2; in_b = 32'd3; in_rd = 5'd4;
    for (int i = 0; i < 5; i++) begin
      chk("hold_stall", {31'd0, stall}, 32'd1);
      chk("hold_wb_valid", {31'd0, wb_valid}, 32'd1);
      flush = (i == 2);
      tick();
      flush = 1'b0;
    end
    chk("hold_unit_a", unit_a, 32'd6);
    push_exp(5'd4, 32'd6, 1'b0);
    ack_one();
    chk("b2b_idle_stall", {31'd0, stall}, 32'd0);
    chk("b2b_idle_ctrl", {31'd0, ctrl_MULT}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("b2b_pulse", {31'd0, ctrl_MULT}, 32'd1);
    chk("b2b_unit_a", unit_a, 32'd2);
    chk("b2b_unit_b", unit_b, 32'd3);
    tick();
    unit_rdy = 1'b1; unit_result = 32'd6;
    tick();
    unit_rdy = 1'b0; unit_result = 32'd0;
    chk("b2b_wb_valid", {31'd0, wb_valid}, 32'd1);
    ack_one();

    // reset mid-operation drops everything
    issue(OP_MULT, 32'd11, 32'd13, 5'd2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_unit_a", unit_a, 32'd0);
    chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("midrst_still_idle", {31'd0, stall}, 32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
